fifo_control: RTL and testbench
===============================

FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, pointer width; FIFO depth SHALL be 2**ADDR_WIDTH.
REQ-002 Parameter AF_LEVEL, default 2**ADDR_WIDTH-2, occupancy at or above which almost_full SHALL assert.
REQ-003 Parameter AE_LEVEL, default 2, occupancy at or below which almost_empty SHALL assert.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push  input  1  write request from the producer.
REQ-007 pop  input  1  read request from the consumer.
REQ-008 wr_en  output  1  memory write strobe, push accepted this cycle.
REQ-009 rd_en  output  1  memory read strobe, pop accepted this cycle.
REQ-010 wr_ptr  output  ADDR_WIDTH  memory write address.
REQ-011 rd_ptr  output  ADDR_WIDTH  memory read address.
REQ-012 fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-014 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 wr_en SHALL be combinational: push & ~full; rd_en SHALL be push-independent: pop & ~empty.
REQ-016 wr_ptr/rd_ptr SHALL be registered; memory SHALL sample the current wr_ptr when wr_en=1, and the pointer SHALL increment by 1 on that same edge.
REQ-017 rd_ptr SHALL present the address of the oldest entry; it SHALL increment by 1 on each edge with rd_en=1.
REQ-018 Pointers SHALL wrap modulo 2**ADDR_WIDTH (all-ones +1 -> 0) with no other effect.
REQ-019 fifo_count SHALL be +1 on wr_en only, -1 on rd_en only, unchanged when both or neither.
REQ-020 full = (fifo_count == 2**ADDR_WIDTH); empty = (fifo_count == 0); both decoded from registered count, zero added latency.
REQ-021 almost_full = (fifo_count >= AF_LEVEL); almost_empty = (fifo_count <= AE_LEVEL).
REQ-022 Push while full, pop absent: write rejected, pointers/count unchanged, overflow SHALL set on that edge.
REQ-023 Push and pop while full: both accepted (rd_en=1, wr_en=0 per REQ-015 is NOT used here) -- full case SHALL gate wr_en with ~full only when pop=0; when full and pop=1, wr_en=1 and count unchanged.
REQ-024 Pop while empty (push either value): read rejected, underflow SHALL set; a simultaneous push SHALL still be accepted.
REQ-025 overflow/underflow SHALL remain 1 until reset.

Reset
REQ-026 On reset=1, asynchronously: wr_ptr=0, rd_ptr=0, fifo_count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-027 wr_en and rd_en SHALL be 0 while reset=1 regardless of push/pop.
REQ-028 Reset asserted mid-operation SHALL discard all occupancy; first accepted push after release SHALL write address 0.

Structure
REQ-029 Default ADDR_WIDTH and threshold defaults SHALL live in shared package fifo_pkg, reused by the memory block.
REQ-030 One sub-module fifo_ptr_counter (ADDR_WIDTH-bit wrapping counter with enable, async reset) SHALL be instantiated twice for wr_ptr and rd_ptr.
REQ-031 wr_ptr/rd_ptr SHALL connect directly to the memory's same-named address ports.

Verification (bench ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-032 After reset, push 1 cycle -> wr_en=1, wr_ptr 0->1, fifo_count=1, empty=0, almost_empty=1.
REQ-033 Push 8 consecutive cycles -> fifo_count=8, full=1, almost_full=1 from count 6; 9th push -> wr_en=0, overflow=1, wr_ptr=0.
REQ-034 From full, push+pop together 3 cycles -> count stays 8, wr_ptr=3, rd_ptr=3, no overflow change.
REQ-035 Pop on empty with push=1 -> rd_en=0, underflow=1, wr_en=1, fifo_count=1.
REQ-036 Fill 5, pop 5, push 5 more -> wr_ptr wraps 7->0, ends 2; rd_ptr=5; count=5.
REQ-037 Assert reset with count=4 mid-stream -> all outputs per REQ-026 immediately, without a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, used by the FIFO controller and the memory block it addresses.
package fifo_pkg;

  localparam int unsigned FifoAddrWidth = 8;
  localparam int unsigned FifoAeLevel   = 2;

  // almost_full threshold sits two entries below the top of the FIFO.
  function automatic int unsigned fifo_af_default(int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd2;
  endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrapping address counter with enable and asynchronous active-high reset.
module fifo_ptr_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Natural binary overflow gives the modulo-2**WIDTH wrap.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_control.sv
// FIFO control path: pointers, occupancy count, status and sticky error flags.
module fifo_control
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FifoAddrWidth,
  parameter int unsigned AF_LEVEL   = fifo_af_default(ADDR_WIDTH),
  parameter int unsigned AE_LEVEL   = FifoAeLevel
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DepthVal = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AfLevel  = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AeLevel  = AE_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  assign full         = (count_q == DepthVal);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfLevel);
  assign almost_empty = (count_q <= AeLevel);

  // A simultaneous pop frees the slot being written, so a full FIFO still accepts push+pop.
  assign wr_en = ~reset & push & (~full | pop);
  assign rd_en = ~reset & pop & ~empty;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q | (push & full & ~pop);
    underflow_d = underflow_q | (pop & empty);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  fifo_ptr_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .en   (wr_en),
    .count(wr_ptr)
  );

  fifo_ptr_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .en   (rd_en),
    .count(rd_ptr)
  );

endmodule

// File: tb/tb_fifo_control.sv
// Directed scoreboard bench for fifo_control with ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2.
module tb_fifo_control;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Expected view of the DUT during one cycle: strobes for this cycle's inputs,
  // registered state as it stands before this cycle's edge.
  typedef struct {
    logic wr;
    logic rd;
    int   wp;
    int   rp;
    int   cnt;
    logic ovf;
    logic udf;
  } exp_t;

  exp_t exp_q[$];

  fifo_control #(
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .fifo_count  (fifo_count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: every sampled cycle with a pending expectation is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_en",        int'(wr_en),        int'(e.wr));
      chk("rd_en",        int'(rd_en),        int'(e.rd));
      chk("wr_ptr",       int'(wr_ptr),       e.wp);
      chk("rd_ptr",       int'(rd_ptr),       e.rp);
      chk("fifo_count",   int'(fifo_count),   e.cnt);
      chk("full",         int'(full),         int'(e.cnt == 8));
      chk("empty",        int'(empty),        int'(e.cnt == 0));
      chk("almost_full",  int'(almost_full),  int'(e.cnt >= 6));
      chk("almost_empty", int'(almost_empty), int'(e.cnt <= 2));
      chk("overflow",     int'(overflow),     int'(e.ovf));
      chk("underflow",    int'(underflow),    int'(e.udf));
    end
  end

  task automatic step(input logic r, input logic p, input logic q,
                      input logic ewr, input logic erd, input int ewp, input int erp,
                      input int ecnt, input logic eovf, input logic eudf);
    exp_t e;
    reset = r;
    push  = p;
    pop   = q;
    e.wr  = ewr;
    e.rd  = erd;
    e.wp  = ewp;
    e.rp  = erp;
    e.cnt = ecnt;
    e.ovf = eovf;
    e.udf = eudf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    @(posedge clk);
    #1;
    // Strobes held low during reset even with push and pop high.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // First push after reset writes address 0.
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // Seven more pushes fill the FIFO; wr_ptr wraps back to 0.
    for (int k = 1; k < 8; k++) step(0, 1, 0, 1, 0, k, 0, k, 0, 0);
    // Push while full: rejected, overflow sets on this edge.
    step(0, 1, 0, 0, 0, 0, 0, 8, 0, 0);
    // Push+pop while full: both accepted, count holds at 8.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, i, i, 8, 1, 0);
    // Drain all eight entries.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 1, 3, (3 + i) % 8, 8 - i, 1, 0);
    // Pop on empty with push: read rejected, write accepted, underflow sets.
    step(0, 1, 1, 1, 0, 3, 3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 4, 3, 1, 1, 1);
    // Reset clears sticky flags and occupancy.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill 5, pop 5, push 5 more: wr_ptr wraps 7 -> 0 and ends at 2.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, i, 0, i, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 5, i, 5 - i, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, (5 + i) % 8, 5, i, 0, 0);
    step(0, 0, 1, 0, 1, 2, 5, 5, 0, 0);
    step(0, 0, 0, 0, 0, 2, 6, 4, 0, 0);
    // Async reset with count=4: sampled before any further clock edge.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // First accepted push after release writes address 0.
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
